cam_scan_ctrl: RTL

CAM_SCAN_CTRL -- requirements
Module: cam_scan_ctrl

---
 rtl/cam_pkg.sv | 21 ++
 rtl/cam_scan_ctrl_if.sv | 36 +++
 rtl/cam_scan_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared CAM definitions: geometry, word type and the scan controller FSM
// state encoding. Imported by the controller, its interface and the bench.
package cam_pkg;

  localparam int CAM_ENTRIES = 32;
  localparam int CAM_WIDTH   = 32;
  localparam int CAM_IDX_W   = 5;

  localparam logic [CAM_IDX_W-1:0] CAM_LAST_IDX = CAM_IDX_W'(CAM_ENTRIES - 1);

  typedef logic [CAM_WIDTH-1:0]   cam_word_t;
  typedef logic [CAM_ENTRIES-1:0] cam_mask_t;
  typedef logic [CAM_IDX_W-1:0]   cam_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } cam_state_t;

endpackage

// File: rtl/cam_scan_ctrl_if.sv
// Signal bundle between the CAM scan controller and its surroundings.
//   search channel : search_valid/search_ready, search_key, entry_valid,
//                    search_abort
//   read mux       : mux_sel (to the external 32x32 mux), mux_data (back)
//   result channel : result_valid/result_ready, result_hit, result_index
// slave  = controller side, master = requester / parent side.
interface cam_scan_ctrl_if;
  import cam_pkg::*;

  logic      search_valid;
  logic      search_ready;
  cam_word_t search_key;
  cam_mask_t entry_valid;
  logic      search_abort;

  cam_idx_t  mux_sel;
  cam_word_t mux_data;

  logic      result_valid;
  logic      result_ready;
  logic      result_hit;
  cam_idx_t  result_index;

  modport slave (
    input  search_valid, search_key, entry_valid, search_abort,
    input  mux_data, result_ready,
    output search_ready, mux_sel, result_valid, result_hit, result_index
  );

  modport master (
    output search_valid, search_key, entry_valid, search_abort,
    output mux_data, result_ready,
    input  search_ready, mux_sel, result_valid, result_hit, result_index
  );

endinterface

// File: rtl/cam_scan_ctrl.sv
// Sequential CAM search controller. Walks an external 32x32 read mux one
// entry per cycle from index 0 upward and reports the lowest valid entry
// whose word equals the latched key.
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - cam_scan_ctrl_if.slave (search, mux and result channels)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | search_ready high, waiting for a search
// SCAN  | one compare per cycle at mux_sel, stepping 0..31
// RESP  | result held on result_* until result_ready
module cam_scan_ctrl
  import cam_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  cam_scan_ctrl_if.slave bus
);

  cam_state_t state_q,   state_d;
  cam_idx_t   mux_sel_q, mux_sel_d;
  cam_word_t  key_q,     key_d;
  cam_mask_t  mask_q,    mask_d;
  logic       hit_q,     hit_d;
  cam_idx_t   index_q,   index_d;

  logic       match;

  // An entry only counts when its valid bit was set at acceptance time.
  assign match = (bus.mux_data == key_q) && mask_q[mux_sel_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mux_sel_q <= '0;
      key_q     <= '0;
      mask_q    <= '0;
      hit_q     <= 1'b0;
      index_q   <= '0;
    end else begin
      state_q   <= state_d;
      mux_sel_q <= mux_sel_d;
      key_q     <= key_d;
      mask_q    <= mask_d;
      hit_q     <= hit_d;
      index_q   <= index_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mux_sel_d = mux_sel_q;
    key_d     = key_q;
    mask_d    = mask_q;
    hit_d     = hit_q;
    index_d   = index_q;

    unique case (state_q)
      IDLE: begin
        if (bus.search_valid) begin
          key_d     = bus.search_key;
          mask_d    = bus.entry_valid;
          mux_sel_d = '0;
          hit_d     = 1'b0;
          index_d   = '0;
          // Nothing can match with an empty mask; answer a miss right away.
          state_d   = (bus.entry_valid == '0) ? RESP : SCAN;
        end
      end

      SCAN: begin
        // Abort wins over a same-cycle match or final miss.
        if (bus.search_abort) begin
          state_d = IDLE;
        end else if (match) begin
          hit_d   = 1'b1;
          index_d = mux_sel_q;
          state_d = RESP;
        end else if (mux_sel_q == CAM_LAST_IDX) begin
          // Leave mux_sel parked at the last entry; no wrap.
          hit_d   = 1'b0;
          index_d = '0;
          state_d = RESP;
        end else begin
          mux_sel_d = mux_sel_q + 1'b1;
        end
      end

      RESP: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.search_ready = (state_q == IDLE);
  assign bus.result_valid = (state_q == RESP);
  assign bus.result_hit   = hit_q;
  assign bus.result_index = index_q;
  assign bus.mux_sel      = mux_sel_q;

endmodule
